microstep_phase_seq: RTL and testbench

Microstep phase sequencer for the two-coil stepper driver. Tracks an 8-bit electrical phase from step/dir pulses, resolves it into quadrant plus 6-bit quarter-wave index, and time-shares a single `cosine` LUT instance to produce scaled coil A (cos) and coil B (sin) duty targets with polarity. Sits directly upstream of the `cosine` LUT and feeds the per-coil PWM/chopper stage.

---
 rtl/microstep_phase_seq_pkg.sv | 61 ++++++
 rtl/microstep_phase_seq_cosine.sv | 25 ++
 rtl/microstep_phase_seq.sv | 159 +++++++++++++++
 tb/tb_microstep_phase_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/microstep_phase_seq_pkg.sv
// Shared types, widths and helper functions for the microstep phase sequencer.
package microstep_pkg;

  localparam int QUAD_BITS  = 2;
  localparam int IDX_BITS   = 6;
  localparam int PHASE_BITS = 8;
  localparam int MAX_SHIFT  = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOK_A = 2'd1,
    S_LOOK_B = 2'd2,
    S_COMMIT = 2'd3
  } state_e;

  // One coil's view of a phase: quarter-wave LUT index plus current polarity.
  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic                pol;
  } coil_sel_t;

  // Phase advance per step: a power of two, clamped so one step never exceeds a quadrant.
  function automatic logic [PHASE_BITS-1:0] step_delta(input logic [2:0] shift);
    logic [PHASE_BITS-1:0] one;
    one = PHASE_BITS'(1);
    if (int'(shift) >= MAX_SHIFT) return one << MAX_SHIFT;
    return one << shift;
  endfunction

  // Coil A follows cos: odd quadrants read the table mirrored, sign negative in q1/q2.
  function automatic coil_sel_t coil_a_sel(input logic [PHASE_BITS-1:0] ph);
    coil_sel_t           s;
    logic [QUAD_BITS-1:0] q;
    logic [IDX_BITS-1:0]  i;
    q     = ph[PHASE_BITS-1:IDX_BITS];
    i     = ph[IDX_BITS-1:0];
    s.idx = q[0] ? ~i : i;           // ~i == 63 - i for a 6-bit index
    s.pol = ~(q[1] ^ q[0]);
    return s;
  endfunction

  // Coil B follows sin: mirrored in even quadrants, sign negative in q2/q3.
  function automatic coil_sel_t coil_b_sel(input logic [PHASE_BITS-1:0] ph);
    coil_sel_t           s;
    logic [QUAD_BITS-1:0] q;
    logic [IDX_BITS-1:0]  i;
    q     = ph[PHASE_BITS-1:IDX_BITS];
    i     = ph[IDX_BITS-1:0];
    s.idx = q[0] ? i : ~i;
    s.pol = ~q[1];
    return s;
  endfunction

  // (lut * (scale + 1)) >> 8, so scale 255 passes the table value through unchanged.
  function automatic logic [7:0] scale_duty(input logic [7:0] lut, input logic [7:0] scale);
    logic [15:0] prod;
    prod = 16'(lut) * (16'(scale) + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/microstep_phase_seq_cosine.sv
// Quarter-wave cosine table: value = round(255 * cos(index * pi / 128)), index 0..63.
module cosine
  import microstep_pkg::*;
(
  input  logic [IDX_BITS-1:0] index_i,
  output logic [7:0]          value_o
);

  localparam logic [7:0] TABLE [64] = '{
    8'd255, 8'd255, 8'd255, 8'd254, 8'd254, 8'd253, 8'd252, 8'd251,
    8'd250, 8'd249, 8'd247, 8'd246, 8'd244, 8'd242, 8'd240, 8'd238,
    8'd236, 8'd233, 8'd231, 8'd228, 8'd225, 8'd222, 8'd219, 8'd215,
    8'd212, 8'd208, 8'd205, 8'd201, 8'd197, 8'd193, 8'd189, 8'd185,
    8'd180, 8'd176, 8'd171, 8'd167, 8'd162, 8'd157, 8'd152, 8'd147,
    8'd142, 8'd136, 8'd131, 8'd126, 8'd120, 8'd115, 8'd109, 8'd103,
    8'd98,  8'd92,  8'd86,  8'd80,  8'd74,  8'd68,  8'd62,  8'd56,
    8'd50,  8'd44,  8'd37,  8'd31,  8'd25,  8'd19,  8'd13,  8'd6
  };

  // Pure combinational lookup.
  always_comb begin
    value_o = TABLE[index_i];
  end

endmodule

// File: rtl/microstep_phase_seq.sv
// Microstep phase sequencer: tracks electrical phase from step/dir and time-shares
// one cosine LUT port to produce coil A (cos) and coil B (sin) duty targets.
module microstep_phase_seq
  import microstep_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  step_i,
  input  logic                  dir_i,
  input  logic [2:0]            step_shift_i,
  input  logic [7:0]            current_scale_i,
  output logic [IDX_BITS-1:0]   cos_index_o,
  input  logic [7:0]            cos_value_i,
  output logic [7:0]            duty_a_o,
  output logic [7:0]            duty_b_o,
  output logic                  pol_a_o,
  output logic                  pol_b_o,
  output logic [PHASE_BITS-1:0] phase_o,
  output logic                  update_o
);

  state_e                state_q, state_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic [PHASE_BITS-1:0] snap_phase_q, snap_phase_d;
  logic [7:0]            snap_scale_q, snap_scale_d;
  logic                  dirty_q, dirty_d;
  logic [7:0]            a_mag_q, a_mag_d;
  logic [7:0]            b_mag_q, b_mag_d;
  logic [7:0]            duty_a_q, duty_a_d;
  logic [7:0]            duty_b_q, duty_b_d;
  logic                  pol_a_q, pol_a_d;
  logic                  pol_b_q, pol_b_d;
  logic                  update_q, update_d;

  logic                  take_snap;
  logic                  dirty_set;
  coil_sel_t             sel_a, sel_b;
  logic [7:0]            lut_scaled;

  // Everything downstream of the snapshot works only from snapshot registers,
  // so a committed A/B pair always belongs to one phase and one scale.
  assign sel_a      = coil_a_sel(snap_phase_q);
  assign sel_b      = coil_b_sel(snap_phase_q);
  assign lut_scaled = scale_duty(cos_value_i, snap_scale_q);

  // Phase follows every step, independent of enable or the lookup FSM.
  always_comb begin
    phase_d = phase_q;
    if (step_i) begin
      phase_d = dir_i ? phase_q + step_delta(step_shift_i)
                      : phase_q - step_delta(step_shift_i);
    end
  end

  // Lookup FSM: snapshot, read A, read B, commit; cos_index parked at 0 otherwise.
  always_comb begin
    state_d     = state_q;
    take_snap   = 1'b0;
    cos_index_o = '0;
    unique case (state_q)
      S_IDLE: begin
        if (enable_i && dirty_q) begin
          take_snap = 1'b1;
          state_d   = S_LOOK_A;
        end
      end
      S_LOOK_A: begin
        cos_index_o = sel_a.idx;
        state_d     = S_LOOK_B;
      end
      S_LOOK_B: begin
        cos_index_o = sel_b.idx;
        state_d     = S_COMMIT;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (!enable_i) state_d = S_IDLE;
  end

  // Dirty marks "outputs may be stale"; a new cause on the snapshot edge wins over the clear.
  // The scale compare is masked on the snapshot edge because that edge captures the live scale.
  always_comb begin
    dirty_set = step_i | ~enable_i |
                ((current_scale_i != snap_scale_q) & ~take_snap);
    dirty_d   = dirty_q;
    if (take_snap) dirty_d = 1'b0;
    if (dirty_set) dirty_d = 1'b1;
  end

  // Datapath: capture snapshot, stage scaled magnitudes, then load outputs as one group.
  always_comb begin
    snap_phase_d = snap_phase_q;
    snap_scale_d = snap_scale_q;
    a_mag_d      = a_mag_q;
    b_mag_d      = b_mag_q;
    duty_a_d     = duty_a_q;
    duty_b_d     = duty_b_q;
    pol_a_d      = pol_a_q;
    pol_b_d      = pol_b_q;
    update_d     = 1'b0;
    if (take_snap) begin
      snap_phase_d = phase_q;
      snap_scale_d = current_scale_i;
    end
    if (state_q == S_LOOK_A) a_mag_d = lut_scaled;
    if (state_q == S_LOOK_B) b_mag_d = lut_scaled;
    if (!enable_i) begin
      duty_a_d = '0;
      duty_b_d = '0;
    end else if (state_q == S_COMMIT) begin
      duty_a_d = a_mag_q;
      duty_b_d = b_mag_q;
      pol_a_d  = sel_a.pol;
      pol_b_d  = sel_b.pol;
      update_d = 1'b1;
    end
  end

  // State register with synchronous reset; reset aborts any in-flight lookup.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      snap_phase_q <= '0;
      snap_scale_q <= '0;
      dirty_q      <= 1'b1;
      a_mag_q      <= '0;
      b_mag_q      <= '0;
      duty_a_q     <= '0;
      duty_b_q     <= '0;
      pol_a_q      <= 1'b1;
      pol_b_q      <= 1'b1;
      update_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      snap_phase_q <= snap_phase_d;
      snap_scale_q <= snap_scale_d;
      dirty_q      <= dirty_d;
      a_mag_q      <= a_mag_d;
      b_mag_q      <= b_mag_d;
      duty_a_q     <= duty_a_d;
      duty_b_q     <= duty_b_d;
      pol_a_q      <= pol_a_d;
      pol_b_q      <= pol_b_d;
      update_q     <= update_d;
    end
  end

  assign duty_a_o = duty_a_q;
  assign duty_b_o = duty_b_q;
  assign pol_a_o  = pol_a_q;
  assign pol_b_o  = pol_b_q;
  assign phase_o  = phase_q;
  assign update_o = update_q;

endmodule

// File: tb/tb_microstep_phase_seq.sv
// Bench for microstep_phase_seq: reset checks, directed latency/corner sequences,
// a vector table, and randomized step/scale/enable traffic against a trig model.
module tb_microstep_phase_seq;

  logic       clk = 1'b0;
  logic       reset, enable, step, dir;
  logic [2:0] shift;
  logic [7:0] scale;
  logic [5:0] cos_index;
  logic [7:0] cos_value;
  logic [7:0] duty_a, duty_b, phase;
  logic       pol_a, pol_b, update;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  microstep_phase_seq dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .step_i(step), .dir_i(dir),
    .step_shift_i(shift), .current_scale_i(scale),
    .cos_index_o(cos_index), .cos_value_i(cos_value),
    .duty_a_o(duty_a), .duty_b_o(duty_b), .pol_a_o(pol_a), .pol_b_o(pol_b),
    .phase_o(phase), .update_o(update)
  );

  cosine u_lut (.index_i(cos_index), .value_o(cos_value));

  localparam real PI = 3.14159265358979323846;

  // Ideal quarter-wave sample, rounded to nearest.
  function automatic int lut(input int k);
    real v;
    v = 255.0 * $cos(real'(k) * PI / 128.0);
    return int'($floor(v + 0.5));
  endfunction

  // Expected {duty_a, duty_b, pol_a, pol_b} for a phase/scale pair.
  // Magnitudes use the quarter-wave folding rule; signs come from cos/sin of the
  // mid-point angle of the phase bucket.
  function automatic logic [17:0] model(input int ph, input int sc);
    int  q, i, ia, ib, da, db;
    real th;
    q  = ph / 64;
    i  = ph % 64;
    ia = (q % 2 == 1) ? 63 - i : i;
    ib = (q % 2 == 1) ? i : 63 - i;
    da = (lut(ia) * (sc + 1)) / 256;
    db = (lut(ib) * (sc + 1)) / 256;
    th = 2.0 * PI * (real'(ph) + 0.5) / 256.0;
    return {8'(da), 8'(db), ($cos(th) > 0.0), ($sin(th) > 0.0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en, input logic [7:0] sc);
    reset = 1'b1; enable = en; scale = sc; step = 1'b0; dir = 1'b0; shift = 3'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [17:0] outs();
    return {duty_a, duty_b, pol_a, pol_b};
  endfunction

  typedef struct {
    logic       en;
    logic       dir;
    logic [2:0] sh;
    logic [7:0] sc;
    int         n;
    logic [7:0] ph;
    logic [7:0] da, db;
    logic       pa, pb;
  } vec_t;

  vec_t vt[10];

  initial begin
    int          ups;
    logic [17:0] first_o, second_o;
    int          mph;
    int          hp[$];
    int          hs[$];
    logic        en_edge;
    int          late_ups;

    vt[0] = '{1'b1, 1'b1, 3'd0, 8'd255, 0, 8'd0,   8'd255, 8'd6,   1'b1, 1'b1};
    vt[1] = '{1'b1, 1'b1, 3'd0, 8'd255, 1, 8'd1,   8'd255, 8'd13,  1'b1, 1'b1};
    vt[2] = '{1'b1, 1'b0, 3'd0, 8'd127, 1, 8'd255, 8'd127, 8'd3,   1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b1, 3'd6, 8'd255, 1, 8'd64,  8'd6,   8'd255, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 3'd7, 8'd255, 1, 8'd64,  8'd6,   8'd255, 1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b1, 3'd3, 8'd255, 3, 8'd24,  8'd212, 8'd147, 1'b1, 1'b1};
    vt[6] = '{1'b1, 1'b0, 3'd5, 8'd63,  3, 8'd160, 8'd45,  8'd46,  1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b1, 3'd6, 8'd0,   2, 8'd128, 8'd0,   8'd0,   1'b0, 1'b0};
    vt[8] = '{1'b1, 1'b1, 3'd6, 8'd200, 3, 8'd192, 8'd4,   8'd200, 1'b1, 1'b0};
    vt[9] = '{1'b0, 1'b1, 3'd2, 8'd255, 2, 8'd8,   8'd0,   8'd0,   1'b1, 1'b1};

    // ---- reset values, then first update 4 edges after release ----
    do_reset(1'b1, 8'd255);
    chk("reset phase", 32'(phase), 32'd0);
    chk("reset outs", 32'({outs(), update, cos_index}), 32'({8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 6'd0}));
    ups = 0;
    repeat (3) begin tick(); if (update) ups++; end
    chk("startup early update", 32'(ups), 32'd0);
    tick();
    chk("startup update", 32'(update), 32'd1);
    chk("startup outs", 32'(outs()), 32'({8'd255, 8'd6, 1'b1, 1'b1}));
    tick();
    chk("startup pulse width", 32'(update), 32'd0);

    // ---- single step latency and LUT index sequencing ----
    step = 1'b1; dir = 1'b1; shift = 3'd0;
    tick();
    step = 1'b0;
    chk("step phase", 32'(phase), 32'd1);
    tick();
    chk("lookA idx", 32'({update, cos_index}), 32'({1'b0, 6'd1}));
    tick();
    chk("lookB idx", 32'({update, cos_index}), 32'({1'b0, 6'd62}));
    tick();
    chk("commit idx", 32'({update, cos_index}), 32'({1'b0, 6'd0}));
    tick();
    chk("step update", 32'(update), 32'd1);
    chk("step outs", 32'(outs()), 32'({8'd255, 8'd13, 1'b1, 1'b1}));
    repeat (3) tick();

    // ---- three back-to-back steps: two coherent updates ----
    repeat (3) begin step = 1'b1; tick(); end
    step = 1'b0;
    ups = 0; first_o = '0; second_o = '0;
    repeat (20) begin
      tick();
      if (update) begin
        ups++;
        if (ups == 1) first_o = outs();
        if (ups == 2) second_o = outs();
      end
    end
    chk("burst update count", 32'(ups), 32'd2);
    chk("burst first pair", 32'(first_o), 32'({8'd255, 8'd19, 1'b1, 1'b1}));
    chk("burst second pair", 32'(second_o), 32'({8'd254, 8'd31, 1'b1, 1'b1}));
    chk("burst phase", 32'(phase), 32'd4);

    // ---- enable dropped while in LOOK_B, then re-enabled ----
    step = 1'b1; dir = 1'b1; shift = 3'd4;
    tick();
    step = 1'b0;
    tick();
    tick();
    enable = 1'b0;
    tick();
    chk("disable outs", 32'({duty_a, duty_b, update}), 32'd0);
    chk("disable phase", 32'(phase), 32'd20);
    ups = 0;
    repeat (4) begin tick(); if (update) ups++; end
    chk("disabled no update", 32'(ups), 32'd0);
    enable = 1'b1;
    repeat (3) begin tick(); if (update) ups++; end
    chk("reenable early update", 32'(ups), 32'd0);
    tick();
    chk("reenable update", 32'(update), 32'd1);
    chk("reenable outs", 32'(outs()), 32'({8'd225, 8'd126, 1'b1, 1'b1}));
    repeat (2) tick();

    // ---- reset mid-computation ----
    step = 1'b1; shift = 3'd0;
    tick();
    step = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("midreset phase", 32'(phase), 32'd0);
    chk("midreset outs", 32'({outs(), update, cos_index}), 32'({8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 6'd0}));
    reset = 1'b0;
    ups = 0;
    repeat (3) begin tick(); if (update) ups++; end
    tick();
    chk("midreset recompute", 32'({ups[1:0], update}), 32'({2'd0, 1'b1}));
    chk("midreset recompute outs", 32'(outs()), 32'({8'd255, 8'd6, 1'b1, 1'b1}));

    // ---- vector table ----
    for (int k = 0; k < 10; k++) begin
      do_reset(vt[k].en, vt[k].sc);
      dir = vt[k].dir; shift = vt[k].sh;
      for (int s = 0; s < vt[k].n; s++) begin step = 1'b1; tick(); end
      step = 1'b0;
      repeat (20) tick();
      chk($sformatf("vec%0d phase", k), 32'(phase), 32'(vt[k].ph));
      chk($sformatf("vec%0d outs", k), 32'(outs()), 32'({vt[k].da, vt[k].db, vt[k].pa, vt[k].pb}));
    end

    // ---- randomized traffic against the trig model ----
    do_reset(1'b1, 8'd255);
    mph = 0;
    for (int c = 0; c < 1500; c++) begin
      int sh;
      step  = ($urandom_range(0, 99) < 35);
      dir   = 1'($urandom_range(0, 1));
      shift = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) scale = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      hp.push_front(mph);
      hs.push_front(int'(scale));
      if (hp.size() > 8) begin void'(hp.pop_back()); void'(hs.pop_back()); end
      sh = (int'(shift) > 6) ? 6 : int'(shift);
      if (step) mph = dir ? (mph + (1 << sh)) % 256 : (mph - (1 << sh) + 256) % 256;
      en_edge = enable;
      tick();
      chk("rand phase", 32'(phase), 32'(mph));
      if (!en_edge) chk("rand disabled", 32'({duty_a, duty_b, update}), 32'd0);
      if (update) begin
        if (hp.size() >= 4) chk("rand update pair", 32'(outs()), 32'(model(hp[3], hs[3])));
        else chk("rand update too early", 32'(hp.size()), 32'd4);
      end
    end
    step = 1'b0;
    enable = 1'b1;
    late_ups = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (c >= 12 && update) late_ups++;
    end
    chk("rand settle quiet", 32'(late_ups), 32'd0);
    chk("rand settle phase", 32'(phase), 32'(mph));
    chk("rand settle outs", 32'(outs()), 32'(model(mph, int'(scale))));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
